// File: rtl/effect_mixer_n_if.sv
// Signal bundle for effect_mixer_n: dry sample in, effect fetch handshake, mixed sample and status out.
// The i_atten member exists only when EFFECT_MIXER_ATTEN_EN is defined.
`timescale 1ns/1ps
interface effect_mixer_n_if #(
    parameter int N_EFF   = 4,
    parameter int D_WIDTH = 24
);
    logic                     i_dv_in;
    logic [D_WIDTH-1:0]       i_data_in;
    logic [N_EFF-1:0]         i_sw;
`ifdef EFFECT_MIXER_ATTEN_EN
    logic [2*N_EFF-1:0]       i_atten;
`endif
    logic [N_EFF-1:0]         o_rd_en;
    logic [N_EFF-1:0]         i_eff_valid;
    logic [N_EFF*D_WIDTH-1:0] i_eff_data;
    logic [D_WIDTH-1:0]       o_data;
    logic                     o_dv;
    logic                     o_busy;
    logic                     o_clip;
    logic                     o_timeout;
    logic [7:0]               o_drop_cnt;
    logic [1:0]               o_dbg_state;

    // Fetch handshake: o_rd_en[k] stays high while the mixer waits on effect k; the effect answers
    // with i_eff_valid[k] and i_eff_data in the same cycle and the sample is taken on that clock edge.
    modport master (
`ifdef EFFECT_MIXER_ATTEN_EN
        input  i_atten,
`endif
        input  i_dv_in, i_data_in, i_sw, i_eff_valid, i_eff_data,
        output o_rd_en, o_data, o_dv, o_busy, o_clip, o_timeout, o_drop_cnt, o_dbg_state
    );

    modport slave (
`ifdef EFFECT_MIXER_ATTEN_EN
        output i_atten,
`endif
        output i_dv_in, i_data_in, i_sw, i_eff_valid, i_eff_data,
        input  o_rd_en, o_data, o_dv, o_busy, o_clip, o_timeout, o_drop_cnt, o_dbg_state
    );
endinterface

// File: rtl/effect_mixer_n.sv
// Per-sample mixer: fetches one sample from each enabled effect in index order, sums and saturates.
// Optional per-effect attenuation shift is enabled with the macro EFFECT_MIXER_ATTEN_EN.
`timescale 1ns/1ps
module effect_mixer_n #(
    parameter int N_EFF   = 4,
    parameter int D_WIDTH = 24,
    parameter int M_WIDTH = 16,
    parameter int TIMEOUT = 256
) (
    input  logic             clk,
    input  logic             reset_n,
    effect_mixer_n_if.master bus
);
    localparam int IW = (N_EFF > 1) ? $clog2(N_EFF) : 1;
    localparam int WW = $clog2(TIMEOUT);
    localparam int AW = M_WIDTH + $clog2(N_EFF) + 1;
    localparam logic [IW-1:0] LAST_IDX  = IW'(N_EFF - 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);
    localparam logic signed [AW-1:0] SAT_MAX = {{(AW-M_WIDTH+1){1'b0}}, {(M_WIDTH-1){1'b1}}};
    localparam logic signed [AW-1:0] SAT_MIN = {{(AW-M_WIDTH+1){1'b1}}, {(M_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_SAT  = 2'd2
    } state_e;

    state_e                    state_q, state_d;
    logic [IW-1:0]             idx_q, idx_d;
    logic [WW-1:0]             wait_q, wait_d;
    logic signed [AW-1:0]      acc_q, acc_d;
    logic [M_WIDTH-1:0]        dry_q, dry_d;
    logic [N_EFF-1:0]          mask_q, mask_d;
    logic [D_WIDTH-1:0]        data_q, data_d;
    logic                      dv_q, dv_d;
    logic                      clip_q, clip_d;
    logic                      timeout_q, timeout_d;
    logic [7:0]                drop_q, drop_d;
`ifdef EFFECT_MIXER_ATTEN_EN
    logic [2*N_EFF-1:0]        atten_q, atten_d;
    logic [1:0]                shift_sel;
    logic signed [AW-1:0]      eff_raw;
`endif

    logic signed [M_WIDTH-1:0] eff_sel;
    logic signed [AW-1:0]      eff_ext;
    logic                      valid_sel;
    logic                      mask_sel;
    logic [N_EFF-1:0]          rd_en;
    logic                      advance;
    logic [M_WIDTH-1:0]        res;
    logic                      unused_lsbs;

    // Everything about the current effect is picked by idx_q; only that channel's request can be high.
    always_comb begin
        eff_sel   = '0;
        valid_sel = 1'b0;
        mask_sel  = 1'b0;
        rd_en     = '0;
`ifdef EFFECT_MIXER_ATTEN_EN
        shift_sel = '0;
`endif
        for (int k = 0; k < N_EFF; k++) begin
            if (idx_q == IW'(k)) begin
                eff_sel   = bus.i_eff_data[k*D_WIDTH + D_WIDTH-1 -: M_WIDTH];
                valid_sel = bus.i_eff_valid[k];
                mask_sel  = mask_q[k];
                rd_en[k]  = (state_q == ST_SCAN) && mask_q[k];
`ifdef EFFECT_MIXER_ATTEN_EN
                shift_sel = atten_q[2*k +: 2];
`endif
            end
        end
`ifdef EFFECT_MIXER_ATTEN_EN
        eff_raw = {{(AW-M_WIDTH){eff_sel[M_WIDTH-1]}}, eff_sel};
        eff_ext = eff_raw >>> shift_sel;
`else
        eff_ext = {{(AW-M_WIDTH){eff_sel[M_WIDTH-1]}}, eff_sel};
`endif
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        wait_d    = wait_q;
        acc_d     = acc_q;
        dry_d     = dry_q;
        mask_d    = mask_q;
        data_d    = data_q;
        dv_d      = 1'b0;
        clip_d    = 1'b0;
        timeout_d = timeout_q;
        drop_d    = drop_q;
        advance   = 1'b0;
        res       = acc_q[M_WIDTH-1:0];
`ifdef EFFECT_MIXER_ATTEN_EN
        atten_d   = atten_q;
`endif

        if (bus.i_dv_in && (state_q != ST_IDLE) && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.i_dv_in) begin
                    dry_d   = bus.i_data_in[D_WIDTH-1 -: M_WIDTH];
                    mask_d  = bus.i_sw;
`ifdef EFFECT_MIXER_ATTEN_EN
                    atten_d = bus.i_atten;
`endif
                    acc_d   = '0;
                    idx_d   = '0;
                    wait_d  = '0;
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (!mask_sel) begin
                    advance = 1'b1;
                end else if (valid_sel) begin
                    acc_d   = acc_q + eff_ext;
                    wait_d  = '0;
                    advance = 1'b1;
                end else if (wait_q == WAIT_LAST) begin
                    // A silent effect contributes nothing rather than stalling the audio path.
                    wait_d    = '0;
                    timeout_d = 1'b1;
                    advance   = 1'b1;
                end else begin
                    wait_d = wait_q + WW'(1);
                end
                if (advance) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_SAT;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            ST_SAT: begin
                if (mask_q == '0) begin
                    res = dry_q;
                end else if (acc_q > SAT_MAX) begin
                    res    = SAT_MAX[M_WIDTH-1:0];
                    clip_d = 1'b1;
                end else if (acc_q < SAT_MIN) begin
                    res    = SAT_MIN[M_WIDTH-1:0];
                    clip_d = 1'b1;
                end
                data_d                     = '0;
                data_d[D_WIDTH-1 -: M_WIDTH] = res;
                dv_d                       = 1'b1;
                state_d                    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            wait_q    <= '0;
            acc_q     <= '0;
            dry_q     <= '0;
            mask_q    <= '0;
            data_q    <= '0;
            dv_q      <= 1'b0;
            clip_q    <= 1'b0;
            timeout_q <= 1'b0;
            drop_q    <= '0;
`ifdef EFFECT_MIXER_ATTEN_EN
            atten_q   <= '0;
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            wait_q    <= wait_d;
            acc_q     <= acc_d;
            dry_q     <= dry_d;
            mask_q    <= mask_d;
            data_q    <= data_d;
            dv_q      <= dv_d;
            clip_q    <= clip_d;
            timeout_q <= timeout_d;
            drop_q    <= drop_d;
`ifdef EFFECT_MIXER_ATTEN_EN
            atten_q   <= atten_d;
`endif
        end
    end

    // Sample LSBs below the arithmetic width are ignored by design.
    always_comb begin
        unused_lsbs = 1'b0;
        for (int b = 0; b < D_WIDTH - M_WIDTH; b++) begin
            unused_lsbs = unused_lsbs ^ bus.i_data_in[b];
            for (int k = 0; k < N_EFF; k++) begin
                unused_lsbs = unused_lsbs ^ bus.i_eff_data[k*D_WIDTH + b];
            end
        end
    end

    assign bus.o_rd_en     = rd_en;
    assign bus.o_data      = data_q;
    assign bus.o_dv        = dv_q;
    assign bus.o_busy      = (state_q != ST_IDLE);
    assign bus.o_clip      = clip_q;
    assign bus.o_timeout   = timeout_q;
    assign bus.o_drop_cnt  = drop_q;
    assign bus.o_dbg_state = state_q;
endmodule

// File: tb/tb_effect_mixer_n.sv
// Self-checking bench for effect_mixer_n: frame-level reference model, per-cycle compare, directed and random frames.
`timescale 1ns/1ps
module tb_effect_mixer_n;
    localparam int N  = 4;
    localparam int D  = 24;
    localparam int M  = 16;
    localparam int TO = 256;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    effect_mixer_n_if #(.N_EFF(N), .D_WIDTH(D)) bus ();

    effect_mixer_n #(.N_EFF(N), .D_WIDTH(D), .M_WIDTH(M), .TIMEOUT(TO)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- effect modules ----------------
    logic [D-1:0] eff_val [N];
    int           eff_dly [N];
    bit           eff_never [N];
    logic [1:0]   eff_att [N];
    int           eff_cnt [N];
    logic [N-1:0] noise = '0;
    logic [N-1:0]   valid_w;
    logic [N*D-1:0] data_w;

    always @(posedge clk) begin
        for (int k = 0; k < N; k++) eff_cnt[k] <= bus.o_rd_en[k] ? eff_cnt[k] + 1 : 0;
    end
    always @(negedge clk) noise = N'($urandom);

    always_comb begin
        valid_w = '0;
        data_w  = '0;
        for (int k = 0; k < N; k++) begin
            data_w[k*D +: D] = eff_val[k];
            if (bus.o_rd_en[k]) valid_w[k] = !eff_never[k] && (eff_cnt[k] >= eff_dly[k]);
            else                valid_w[k] = noise[k];
        end
    end
    assign bus.i_eff_valid = valid_w;
    assign bus.i_eff_data  = data_w;
`ifdef EFFECT_MIXER_ATTEN_EN
    logic [2*N-1:0] atten_w;
    always_comb begin
        atten_w = '0;
        for (int k = 0; k < N; k++) atten_w[2*k +: 2] = eff_att[k];
    end
    assign bus.i_atten = atten_w;
`endif

    // ---------------- reference model state ----------------
    logic [D:0]   exp_q[$];
    int           exp_t_q[$];
    int           exp_rd_q[$];
    int           busy_from = 1, busy_until = 0;
    int           timeout_from = 32'h7fffffff;
    int           drop_m = 0;
    logic [N-1:0] mask_m = '0;
    logic [D-1:0] hold_m = '0;
    bit           in_reset = 1'b1;
    int           rd_acc = 0;
    int           last_rd = 0, last_dv_cyc = 0, last_acc_cyc = 0, dv_count = 0;
    logic [D-1:0] last_data = '0;
    logic         last_clip = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h cyc=%0d", name, act, req, cyc);
        end
    endtask

    // Frame outcome from the rules: sum of enabled samples' upper bits, clamped; bypass when nothing enabled.
    task automatic model_frame(input logic [D-1:0] data, input logic [N-1:0] sw, input int c,
                               output logic [D-1:0] r, output logic cl, output int scan,
                               output int rdc, output int tof);
        int sum, s, cost, v;
        r = '0; cl = 1'b0; sum = 0; scan = 0; rdc = 0; tof = 32'h7fffffff; s = c + 1;
        for (int k = 0; k < N; k++) begin
            if (!sw[k]) cost = 1;
            else if (eff_never[k]) begin
                cost = TO;
                if (s + TO < tof) tof = s + TO;
            end else begin
                cost = eff_dly[k] + 1;
                v = $signed(eff_val[k][D-1 -: M]);
`ifdef EFFECT_MIXER_ATTEN_EN
                v = v >>> eff_att[k];
`endif
                sum += v;
            end
            if (sw[k]) rdc += cost;
            s += cost;
            scan += cost;
        end
        if (sw == '0) r[D-1 -: M] = data[D-1 -: M];
        else begin
            if (sum > (2**(M-1)) - 1) begin sum = (2**(M-1)) - 1; cl = 1'b1; end
            else if (sum < -(2**(M-1))) begin sum = -(2**(M-1)); cl = 1'b1; end
            r[D-1 -: M] = sum[M-1:0];
        end
    endtask

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (!in_reset) begin
            logic [N-1:0] allowed;
            logic [D:0]   e;
            allowed = ((cyc >= busy_from) && (cyc <= busy_until)) ? mask_m : '0;
            rd_acc += $countones(bus.o_rd_en);
            chk("busy", bus.o_busy, (cyc >= busy_from) && (cyc <= busy_until));
            chk("timeout", bus.o_timeout, cyc >= timeout_from);
            chk("drop_cnt", bus.o_drop_cnt, drop_m);
            chk("rd_en_onehot", $onehot0(bus.o_rd_en), 1);
            chk("rd_en_allowed", bus.o_rd_en & ~allowed, 0);
            if (bus.o_dv) begin
                dv_count++;
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL dv_unexpected actual=1 required=0 cyc=%0d", cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("data", bus.o_data, e[D-1:0]);
                    chk("clip", bus.o_clip, e[D]);
                    chk("dv_time", cyc, exp_t_q.pop_front());
                    chk("rd_cycles", rd_acc, exp_rd_q.pop_front());
                    hold_m = e[D-1:0];
                end
                last_rd = rd_acc; last_data = bus.o_data; last_clip = bus.o_clip; last_dv_cyc = cyc;
                rd_acc = 0;
            end else begin
                chk("clip_idle", bus.o_clip, 0);
                chk("data_hold", bus.o_data, hold_m);
                if (exp_t_q.size() != 0 && cyc > exp_t_q[0]) begin
                    checks++; errors++;
                    $display("FAIL dv_missing actual=0 required=1 cyc=%0d", cyc);
                    void'(exp_q.pop_front()); void'(exp_t_q.pop_front()); void'(exp_rd_q.pop_front());
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_dv(input logic [D-1:0] data, input logic [N-1:0] sw);
        int c, scan, rdc, tof;
        logic [D-1:0] r;
        logic cl;
        bit acc;
        bus.i_data_in = data; bus.i_sw = sw; bus.i_dv_in = 1'b1;
        c = cyc;
        acc = !((c >= busy_from) && (c <= busy_until));
        if (acc) begin
            model_frame(data, sw, c, r, cl, scan, rdc, tof);
            busy_from = c + 1;
            busy_until = c + scan + 1;
            mask_m = sw;
            exp_q.push_back({cl, r});
            exp_t_q.push_back(c + scan + 2);
            exp_rd_q.push_back(rdc);
            if (tof < timeout_from) timeout_from = tof;
            last_acc_cyc = c + 1;
        end
        @(posedge clk);
        if (!acc && drop_m < 255) drop_m++;
        @(negedge clk);
        bus.i_dv_in = 1'b0; bus.i_sw = N'($urandom); bus.i_data_in = D'($urandom);
    endtask

    task automatic wait_idle(input int bound);
        int n = 0;
        while (cyc <= busy_until && n < bound) begin @(negedge clk); n++; end
        if (n >= bound) begin
            checks++; errors++;
            $display("FAIL wait_idle actual=%0d required<%0d cyc=%0d", n, bound, cyc);
        end
    endtask

    task automatic set_eff(input int k, input logic [D-1:0] v, input int dly, input bit nev);
        eff_val[k] = v; eff_dly[k] = dly; eff_never[k] = nev; eff_att[k] = 2'd0;
    endtask

    task automatic directed(input logic [D-1:0] data, input logic [N-1:0] sw);
        send_dv(data, sw);
        wait_idle(3000);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int d0;
        bus.i_dv_in = 1'b0; bus.i_sw = '0; bus.i_data_in = '0;
        for (int k = 0; k < N; k++) set_eff(k, '0, 0, 1'b0);
        repeat (2) @(negedge clk);
        chk("rst_data", bus.o_data, 0);
        chk("rst_dv", bus.o_dv, 0);
        chk("rst_busy", bus.o_busy, 0);
        chk("rst_rd_en", bus.o_rd_en, 0);
        chk("rst_clip", bus.o_clip, 0);
        chk("rst_timeout", bus.o_timeout, 0);
        chk("rst_drop", bus.o_drop_cnt, 0);
        chk("rst_state", bus.o_dbg_state, 0);
        reset_n = 1'b1;
        in_reset = 1'b0;
        @(negedge clk);

        directed(24'h123456, 4'b0000);
        chk("bypass_data", last_data, 24'h123400);
        chk("bypass_clip", last_clip, 0);
        chk("bypass_latency", last_dv_cyc - last_acc_cyc, 5);
        chk("bypass_rd", last_rd, 0);
        @(negedge clk);

        set_eff(0, 24'h100000, 0, 1'b0); set_eff(2, 24'h200000, 0, 1'b0);
        directed(24'h000000, 4'b0101);
        chk("sum_data", last_data, 24'h300000);
        chk("sum_rd", last_rd, 2);
        @(negedge clk);

        set_eff(0, 24'h7FFF00, 0, 1'b0); set_eff(1, 24'h7FFF00, 0, 1'b0);
        directed(24'h000000, 4'b0011);
        chk("satp_data", last_data, 24'h7FFF00);
        chk("satp_clip", last_clip, 1);
        @(negedge clk);
        set_eff(0, 24'h800000, 0, 1'b0); set_eff(1, 24'h800000, 0, 1'b0);
        directed(24'h000000, 4'b0011);
        chk("satn_data", last_data, 24'h800000);
        chk("satn_clip", last_clip, 1);
        @(negedge clk);

        set_eff(1, 24'h0ABCDE, 10, 1'b0);
        directed(24'h555555, 4'b0010);
        chk("late_data", last_data, 24'h0ABC00);
        chk("late_rd", last_rd, 11);
        chk("late_latency", last_dv_cyc - last_acc_cyc, 15);
        @(negedge clk);

        set_eff(0, 24'h010000, 0, 1'b0);
        d0 = dv_count;
        send_dv(24'h000000, 4'b0001);
        @(negedge clk);
        send_dv(24'h777777, 4'b1111);
        wait_idle(100);
        repeat (3) @(negedge clk);
        chk("drop_one", bus.o_drop_cnt, 1);
        chk("drop_single_dv", dv_count - d0, 1);

        set_eff(1, 24'h0ABCDE, 0, 1'b1);
        directed(24'h333333, 4'b0010);
        chk("to_data", last_data, 24'h000000);
        chk("to_flag", bus.o_timeout, 1);
        chk("to_rd", last_rd, TO);
        @(negedge clk);

        for (int f = 0; f < 40; f++) begin
            for (int k = 0; k < N; k++) begin
                set_eff(k, D'($urandom), $urandom_range(0, 5), $urandom_range(0, 19) == 0);
                eff_att[k] = 2'($urandom);
            end
            send_dv(D'($urandom), N'($urandom));
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(0, 4)) @(negedge clk);
                send_dv(D'($urandom), N'($urandom));
            end
            wait_idle(5000);
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end
        wait_idle(5000);
        @(negedge clk);

        for (int k = 0; k < N; k++) set_eff(k, 24'h111111, 0, 1'b1);
        send_dv(24'h000000, 4'b1111);
        for (int i = 0; i < 300; i++) send_dv(D'($urandom), N'($urandom));
        #1;
        chk("drop_sat", bus.o_drop_cnt, 255);
        wait_idle(3000);
        @(negedge clk);

        for (int k = 0; k < N; k++) set_eff(k, 24'h222222, 0, 1'b0);
        set_eff(1, 24'h222222, 0, 1'b1);
        d0 = dv_count;
        send_dv(24'h444444, 4'b0010);
        repeat (20) @(negedge clk);
        in_reset = 1'b1;
        #1 reset_n = 1'b0;
        #1;
        chk("abort_rd_en", bus.o_rd_en, 0);
        chk("abort_busy", bus.o_busy, 0);
        exp_q.delete(); exp_t_q.delete(); exp_rd_q.delete();
        busy_from = 1; busy_until = 0; timeout_from = 32'h7fffffff; drop_m = 0; hold_m = '0; rd_acc = 0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        in_reset = 1'b0;
        #1;
        chk("after_busy", bus.o_busy, 0);
        chk("after_drop", bus.o_drop_cnt, 0);
        chk("after_timeout", bus.o_timeout, 0);
        chk("after_data", bus.o_data, 0);
        @(negedge clk);
        repeat (300) @(negedge clk);
        chk("abort_no_dv", dv_count - d0, 0);

        set_eff(1, 24'hFF0000, 2, 1'b0);
        directed(24'h000000, 4'b0010);
        chk("post_data", last_data, 24'hFF0000);
        @(negedge clk);
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=running required=finished cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/effect_mixer_n.md
Name: effect_mixer_n

Overview:
- Per-sample mixer between the I2S receive path and the I2S transmit path.
- Accepts one dry sample per frame. Fetches one sample from each switch-enabled effect module over a request/valid handshake, in index order.
- Sums the fetched samples at memory width, saturates the sum, and presents it as a 24-bit word for transmit.
- Parametrised successor of the fixed two-effect wiring: N effect channels, timeout protection, clip/drop/timeout status.

Parameters:
- N_EFF, 4, number of effect input channels (1..16).
- D_WIDTH, 24, I2S sample width.
- M_WIDTH, 16, arithmetic width; the upper M_WIDTH bits of every sample are used, the lower bits are ignored.
- TIMEOUT, 256, maximum clk cycles to wait for one effect's valid (>=2).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- i_dv_in  in  1  one-cycle strobe: dry sample available.
- i_data_in  in  D_WIDTH  dry sample, signed.
- i_sw  in  N_EFF  effect enable switches.
- o_rd_en  out  N_EFF  read request to effect k.
- i_eff_valid  in  N_EFF  effect k data valid.
- i_eff_data  in  N_EFF*D_WIDTH  effect k data at bits [k*D_WIDTH +: D_WIDTH], signed.
- o_data  out  D_WIDTH  mixed sample; lower D_WIDTH-M_WIDTH bits are zero.
- o_dv  out  1  one-cycle strobe: o_data updated.
- o_busy  out  1  high in any state other than IDLE.
- o_clip  out  1  high together with o_dv when the sum saturated.
- o_timeout  out  1  sticky; set when any fetch timed out.
- o_drop_cnt  out  8  saturating count of dry strobes dropped while busy.

Behaviour:
- Reset (reset_n low, asynchronous): state=IDLE; all outputs 0; accumulator, index, wait counter, o_drop_cnt and o_timeout cleared. A reset mid-frame drops o_rd_en in the same instant and abandons the frame; no o_dv is produced for it.
- States: IDLE, SCAN, SAT.
- IDLE:
  - On i_dv_in=1, latch i_data_in[D_WIDTH-1 -: M_WIDTH] as the dry value and i_sw as the frame enable mask.
  - Clear the accumulator, set index=0, go to SCAN.
  - i_sw changes after this point have no effect on the current frame.
- SCAN, index k:
  - Mask bit k = 0: o_rd_en[k]=0; advance k next cycle.
  - Mask bit k = 1: o_rd_en[k]=1, combinationally from state and index.
    - If i_eff_valid[k]=1 in the same cycle: add sign-extended i_eff_data upper M_WIDTH bits to the accumulator, clear the wait counter, advance.
    - Otherwise increment the wait counter and stay on k.
    - When the counter reaches TIMEOUT-1 without valid: contribute 0, set o_timeout, advance.
  - Only the current index's o_rd_en bit can be high; at most one bit is high at a time.
  - After k=N_EFF-1, go to SAT.
  - Cost: 1 cycle per disabled index; 1+wait cycles per enabled index.
- Accumulator width: M_WIDTH+clog2(N_EFF)+1, signed.
- SAT (1 cycle):
  - Mask all zero: result = dry value (bypass).
  - Otherwise result = accumulator clipped to [-2^(M_WIDTH-1), 2^(M_WIDTH-1)-1]; o_clip=1 if clipping occurred.
  - Register o_data={result, zeros}, pulse o_dv for 1 cycle, return to IDLE.
  - o_data holds its value until the next o_dv.
- Latency with immediate valids: o_dv is high after edge N_EFF+1, counted from the edge that samples i_dv_in.
- i_dv_in=1 while busy (including the SAT cycle): the sample is ignored and o_drop_cnt increments, saturating at 255.
- i_eff_valid on a non-requested channel is ignored.
- Back-to-back frames: a new i_dv_in is accepted in the first IDLE cycle after SAT.

Optional Feature:
- Macro EFFECT_MIXER_ATTEN_EN.
- Defined: adds input port i_atten (2*N_EFF bits). Effect k's sample is arithmetic-right-shifted by i_atten[2k+1:2k] (0..3) before accumulation. The shift amount is latched with the mask in IDLE. The dry bypass is never attenuated. Saturation is unchanged.
- Undefined: port absent; samples are added unshifted.

Test Plan:
- N_EFF=4, sw=4'b0000, i_data_in=24'h123456 -> no o_rd_en pulses; o_dv after 5 edges; o_data=24'h123400; o_clip=0.
- sw=4'b0101, eff0=24'h100000, eff2=24'h200000, valids immediate -> o_rd_en[0] then o_rd_en[2] high 1 cycle each; bits 1 and 3 never high; o_data=24'h300000.
- sw=4'b0011, both effects 24'h7FFF00 -> o_data=24'h7FFF00, o_clip=1. Both effects 24'h800000 -> o_data=24'h800000, o_clip=1.
- sw=4'b0010, eff1 valid 10 cycles late -> o_rd_en[1] high 11 cycles; latency 15 edges; result correct. Same setup with eff1 never valid, TIMEOUT=256 -> eff1 contributes 0; o_timeout=1 and stays 1 until reset.
- Second i_dv_in 2 cycles after the first -> ignored; o_drop_cnt=1; exactly one o_dv. 300 dropped strobes -> o_drop_cnt=255.
- reset_n asserted low during a SCAN wait -> o_rd_en=0 immediately; after release: o_busy=0, no o_dv for the aborted frame, all counters 0.
